// File: rtl/uart_pkg.sv
// uart_pkg: definitions shared by the UART blocks.
//   uart_state_e    : transmitter frame state, 2-bit encoding
//   DEFAULT_CLK_DIV : default clock cycles per bit period
//   cnt_width()     : counter width helper, never narrower than 1 bit
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_e;

  localparam int DEFAULT_CLK_DIV = 104;

  // Width needed to count 0..n-1. Clamped to 1 so that small values still
  // give a legal vector declaration.
  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// uart_baud_gen: bit-period divider shared by the UART transmitter and receiver.
//   clk_i      : clock
//   areset_ni  : asynchronous active-low reset
//   restart_i  : forces the count back to 0 on the next edge
//   bit_done_o : single-cycle strobe in the last cycle of each bit period
module uart_baud_gen
  import uart_pkg::*;
#(
  parameter int CLK_DIV = DEFAULT_CLK_DIV
) (
  input  logic clk_i,
  input  logic areset_ni,
  input  logic restart_i,
  output logic bit_done_o
);

  localparam int CNT_W = cnt_width(CLK_DIV);

  logic [CNT_W-1:0] count_q, count_d;

  assign bit_done_o = (count_q == CNT_W'(CLK_DIV - 1));

  // Next count: restart wins, otherwise count 0..CLK_DIV-1 and wrap, so every
  // period after a restart is exactly CLK_DIV cycles long.
  always_comb begin
    count_d = count_q;
    if (restart_i || bit_done_o) begin
      count_d = '0;
    end else begin
      count_d = count_q + CNT_W'(1);
    end
  end

  // Divider register.
  always_ff @(posedge clk_i or negedge areset_ni) begin
    if (!areset_ni) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/uart_tx_drain.sv
// uart_tx_drain: drains bytes from a first-word-fall-through FIFO read port
// and serialises each as a frame: start bit (0), DATA_WIDTH data bits LSB
// first, STOP_BITS stop periods (1). All in the FIFO read clock domain.
//   clk          : clock shared with the FIFO read port
//   areset_n     : asynchronous active-low reset
//   tx_enable    : permits a new frame to start; never aborts one in progress
//   fifo_data    : FIFO head entry, valid while fifo_empty is low
//   fifo_empty   : FIFO empty flag
//   fifo_read_en : pop strobe, one cycle per byte (the capture cycle)
//   tx           : serial line, idles high
//   busy         : high from the capture edge to the end of the last stop bit
module uart_tx_drain
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int CLK_DIV    = DEFAULT_CLK_DIV,
  parameter int STOP_BITS  = 1
) (
  input  logic                  clk,
  input  logic                  areset_n,
  input  logic                  tx_enable,
  input  logic [DATA_WIDTH-1:0] fifo_data,
  input  logic                  fifo_empty,
  output logic                  fifo_read_en,
  output logic                  tx,
  output logic                  busy
);

  // One index register serves both data bits and stop periods.
  localparam int IDX_W = cnt_width((DATA_WIDTH > STOP_BITS) ? DATA_WIDTH : STOP_BITS);

  uart_state_e           state_q, state_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic                  tx_q, tx_d;
  logic                  busy_q, busy_d;
  logic                  bit_done;
  logic                  restart;

  // The pop and the capture share one edge; reset gating keeps a pop from
  // being issued while the register state is being cleared.
  assign fifo_read_en = (state_q == IDLE) && !fifo_empty && tx_enable && areset_n;

  // Hold the divider at 0 while idle and restart it on every state entry.
  assign restart = (state_q == IDLE) || (state_d != state_q);

  assign tx   = tx_q;
  assign busy = busy_q;

  uart_baud_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_baud (
    .clk_i      (clk),
    .areset_ni  (areset_n),
    .restart_i  (restart),
    .bit_done_o (bit_done)
  );

  // Frame sequencer. tx and busy are computed for the state being entered so
  // that the registered outputs change on the same edge as the state.
  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    idx_d   = idx_q;
    tx_d    = tx_q;
    busy_d  = busy_q;
    unique case (state_q)
      IDLE: begin
        tx_d   = 1'b1;
        busy_d = 1'b0;
        if (fifo_read_en) begin
          state_d = START;
          shift_d = fifo_data;
          idx_d   = '0;
          tx_d    = 1'b0;
          busy_d  = 1'b1;
        end
      end
      START: begin
        if (bit_done) begin
          state_d = DATA;
          idx_d   = '0;
          tx_d    = shift_q[0];
        end
      end
      DATA: begin
        if (bit_done) begin
          if (idx_q == IDX_W'(DATA_WIDTH - 1)) begin
            state_d = STOP;
            idx_d   = '0;
            tx_d    = 1'b1;
          end else begin
            // The bit after the shift is the current bit 1.
            shift_d = shift_q >> 1;
            idx_d   = idx_q + IDX_W'(1);
            tx_d    = shift_q[1];
          end
        end
      end
      STOP: begin
        if (bit_done) begin
          if (idx_q == IDX_W'(STOP_BITS - 1)) begin
            state_d = IDLE;
            tx_d    = 1'b1;
            busy_d  = 1'b0;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      default: begin
        state_d = IDLE;
        tx_d    = 1'b1;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and output registers; reset forces the line idle at once.
  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) begin
      state_q <= IDLE;
      shift_q <= '0;
      idx_q   <= '0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      idx_q   <= idx_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
    end
  end

endmodule

// File: doc/uart_tx_drain.md
Name: uart_tx_drain

Overview:
- UART transmitter placed directly downstream of the read side of the design's async FIFO. It drains bytes from the FIFO and serialises them as 8N1-style frames on a single TX line.
- It runs entirely in the FIFO read clock domain and pops an entry only when the FIFO reports non-empty.
- FIFO read data is first-word-fall-through: `fifo_data` is valid whenever `fifo_empty` is low, with no read latency.

Parameters:
- DATA_WIDTH, 8: frame payload width; must match the FIFO data width.
- CLK_DIV, 104: clock cycles per bit period; minimum 2.
- STOP_BITS, 1: number of stop bit periods, 1 or 2.

Ports:
- clk  input  1  clock shared with the FIFO read port.
- areset_n  input  1  asynchronous active-low reset.
- tx_enable  input  1  allows a new frame to start; does not abort a frame in progress.
- fifo_data  input  DATA_WIDTH  FIFO head entry, valid while `fifo_empty`=0.
- fifo_empty  input  1  FIFO empty flag.
- fifo_read_en  output  1  pop strobe to the FIFO; one cycle per byte.
- tx  output  1  serial line, idles high.
- busy  output  1  high from the capture edge until the end of the last stop bit.

Behaviour:
- Reset (asynchronous, areset_n=0):
  - tx=1, busy=0, fifo_read_en=0.
  - State IDLE; bit counter and divider counter cleared.
  - Reset mid-frame drops tx to idle-high immediately; the byte in flight is lost and the FIFO is not re-read.
- `fifo_read_en` is combinational: (state==IDLE) && !fifo_empty && tx_enable && areset_n.
  - On that clock edge: `fifo_data` is latched into the shift register, state becomes START, busy is set.
  - The FIFO advances on the same edge, so exactly one pop occurs per frame.
- States:
  - IDLE: tx=1, busy=0. Leaves only via the capture condition above.
  - START: tx=0 for CLK_DIV cycles, then go to DATA with bit index 0.
  - DATA: tx = shift register bit 0 (LSB first), each bit held CLK_DIV cycles. After each bit period, shift right and increment the index. After bit DATA_WIDTH-1, go to STOP.
  - STOP: tx=1 for STOP_BITS*CLK_DIV cycles, then go to IDLE; busy clears on that edge.
- Outputs are registered: tx and busy change on the clock edge that enters a state.
  - The first start-bit cycle is the cycle after the capture edge.
- Divider:
  - Counts 0..CLK_DIV-1 and wraps.
  - Reset to 0 on every state entry, so each bit period is exactly CLK_DIV cycles.
  - Width is $clog2(CLK_DIV).
- Frame length is (1+DATA_WIDTH+STOP_BITS)*CLK_DIV cycles of busy=1.
- Back-to-back frames: one IDLE cycle (tx=1) separates the end of the stop period from the next capture. The start-to-start spacing is frame length + 1 cycles.
- Boundary cases:
  - `tx_enable` falling mid-frame: the current frame completes; no new capture.
  - `fifo_empty` rising mid-frame: no effect.
  - `fifo_empty`=1 in IDLE: no pop, and `fifo_read_en` never asserts.
  - `fifo_data` is ignored outside the capture cycle.

Decomposition:
- Shared package uart_pkg holds:
  - the state enum (IDLE, START, DATA, STOP) with a 2-bit encoding;
  - the default CLK_DIV constant;
  - localparam helpers for counter widths.
- One natural sub-module, uart_baud_gen:
  - a parameterised divider with `restart` input and single-cycle `bit_done` output (asserted when count==CLK_DIV-1);
  - shared with a future uart_rx.

Test Plan:
1. Single byte: CLK_DIV=4, DATA_WIDTH=8, push 0xA5, tx_enable=1.
   - `fifo_read_en` is high for exactly 1 cycle.
   - tx then shows 0,1,0,1,0,0,1,0,1,1, each value held 4 cycles.
   - busy is high for 40 cycles, then tx=1 and busy=0.
2. Back-to-back: CLK_DIV=4, push 0x00 and 0xFF.
   - Two pops in total.
   - The second start bit falls 41 cycles after the first.
   - Data of frame 2 is all ones; the FIFO ends empty.
3. Empty and enable gating:
   - FIFO empty for 100 cycles: `fifo_read_en`=0, tx=1, busy=0 throughout.
   - Then push 0x3C with tx_enable=0: no pop. Raising tx_enable pops on the next edge.
4. Reset mid-frame: assert areset_n=0 during bit 3 of 0x5A.
   - tx=1 and busy=0 immediately, with no clock needed.
   - After release, the next FIFO byte transmits cleanly and 0x5A is not resent.
5. Two stop bits and a large divider: STOP_BITS=2, CLK_DIV=7, byte 0x81.
   - Stop period lasts 14 cycles.
   - Total busy is 77 cycles; the LSB (1) follows the start bit.
6. Disable mid-frame: drop tx_enable during the DATA state with 2 bytes queued.
   - The current frame completes.
   - The second byte stays in the FIFO (`fifo_empty`=0) and is not popped until tx_enable returns.
